// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the split-bus memory responder.
package mem_responder_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned WAIT_W     = 4;
  localparam int unsigned BYTESEL_W  = 2;

  // Value returned for data-bus I/O reads, which are not backed by anything here.
  localparam logic [DATA_W-1:0] IO_FLOAT_VALUE = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } MemRespState_t;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } BusGrant_t;

  // Transaction attributes captured when a bus is granted.
  typedef struct packed {
    BusGrant_t              owner;
    logic                   wr_en;
    logic [BYTESEL_W-1:0]   bytesel;
    logic [DATA_W-1:0]      wr_data;
    logic                   io;
  } mem_req_t;

  // Round-robin choice: on a tie the bus that was not served last wins.
  function automatic BusGrant_t arbitrate(input logic      instr_req,
                                          input logic      data_req,
                                          input BusGrant_t last_grant);
    BusGrant_t grant;
    grant = GRANT_INSTR;
    if (instr_req && data_req) begin
      if (last_grant == GRANT_INSTR) begin
        grant = GRANT_DATA;
      end else begin
        grant = GRANT_INSTR;
      end
    end else if (data_req) begin
      grant = GRANT_DATA;
    end
    return grant;
  endfunction

endpackage

// File: rtl/mem_responder_byte_ram.sv
// Single-port synchronous word RAM with per-byte write enables and 1-cycle read latency.
module ByteRam
  import mem_responder_pkg::*;
#(
  parameter int unsigned addr_bits = 14
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 wr_en,
  input  logic [1:0]           bytesel,
  input  logic [addr_bits-1:0] addr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic [DATA_W-1:0]    rd_data
);

  localparam int unsigned DEPTH = 2 ** addr_bits;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-masked write, or full-word read into the held read register.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wr_en) begin
        if (bytesel[0]) begin
          mem_q[addr][7:0] <= wr_data[7:0];
        end
        if (bytesel[1]) begin
          mem_q[addr][15:8] <= wr_data[15:8];
        end
      end else begin
        rd_data <= mem_q[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Arbitrates instruction and data busses onto one on-chip RAM and returns one ack per access.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned addr_bits   = 14,
  parameter int unsigned wait_states = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  output logic [15:0] instr_m_data_in,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  input  logic [19:1] data_m_addr,
  output logic [15:0] data_m_data_in,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic        d_io
);

  MemRespState_t        state_q, state_d;
  BusGrant_t            last_grant_q, last_grant_d;
  BusGrant_t            grant_c;
  mem_req_t             req_q, req_d;
  logic [addr_bits-1:0] addr_q, addr_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 instr_ack_q, instr_ack_d;
  logic                 data_ack_q, data_ack_d;
  logic                 ram_en_c;
  logic [DATA_W-1:0]    ram_rd_data;
  logic [DATA_W-1:0]    rd_word_c;
  logic                 unused_addr_hi_c;

  // Address bits above the RAM depth are intentionally ignored, so accesses wrap.
  assign unused_addr_hi_c = ^{instr_m_addr[19:addr_bits+1], data_m_addr[19:addr_bits+1]};

  // Next-state, request capture and ack generation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    addr_d       = addr_q;
    wait_cnt_d   = wait_cnt_q;
    instr_ack_d  = 1'b0;
    data_ack_d   = 1'b0;
    ram_en_c     = 1'b0;
    grant_c      = arbitrate(instr_m_access, data_m_access, last_grant_q);

    case (state_q)
      IDLE: begin
        if (instr_m_access || data_m_access) begin
          req_d.owner = grant_c;
          if (grant_c == GRANT_DATA) begin
            addr_d        = data_m_addr[addr_bits:1];
            req_d.wr_en   = data_m_wr_en;
            req_d.bytesel = data_m_bytesel;
            req_d.wr_data = data_m_data_out;
            req_d.io      = d_io;
          end else begin
            addr_d        = instr_m_addr[addr_bits:1];
            req_d.wr_en   = 1'b0;
            req_d.bytesel = 2'b11;
            req_d.wr_data = '0;
            req_d.io      = 1'b0;
          end
          state_d = MEM;
        end
      end

      MEM: begin
        // A reset asserted in this cycle must not let the write land.
        ram_en_c   = !req_q.io && reset;
        wait_cnt_d = WAIT_W'(wait_states);
        if (wait_states == 0) begin
          state_d     = ACK;
          instr_ack_d = (req_q.owner == GRANT_INSTR);
          data_ack_d  = (req_q.owner == GRANT_DATA);
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        if (wait_cnt_q <= WAIT_W'(1)) begin
          state_d     = ACK;
          instr_ack_d = (req_q.owner == GRANT_INSTR);
          data_ack_d  = (req_q.owner == GRANT_DATA);
        end
      end

      ACK: begin
        last_grant_d = req_q.owner;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_INSTR;
      req_q        <= '0;
      addr_q       <= '0;
      wait_cnt_q   <= '0;
      instr_ack_q  <= 1'b0;
      data_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      wait_cnt_q   <= wait_cnt_d;
      instr_ack_q  <= instr_ack_d;
      data_ack_q   <= data_ack_d;
    end
  end

  ByteRam #(
    .addr_bits (addr_bits)
  ) u_ram (
    .clk     (clk),
    .en      (ram_en_c),
    .wr_en   (req_q.wr_en),
    .bytesel (req_q.bytesel),
    .addr    (addr_q),
    .wr_data (req_q.wr_data),
    .rd_data (ram_rd_data)
  );

  // I/O reads see a floating bus; memory reads see the held RAM read register.
  assign rd_word_c = req_q.io ? IO_FLOAT_VALUE : ram_rd_data;

  // Read data is presented only to the bus being acked.
  assign instr_m_ack     = instr_ack_q;
  assign data_m_ack      = data_ack_q;
  assign instr_m_data_in = instr_ack_q ? rd_word_c : '0;
  assign data_m_data_in  = data_ack_q  ? rd_word_c : '0;

endmodule
